comparador_find_max: RTL and testbench
======================================

# comparador_find_max

Streaming maximum finder for the findMax datapath. While the controlling FSM asserts `startFromFSM`, the block samples the memory read data `douta` every clock and keeps the largest unsigned value seen in the current run. It also keeps the position of that value and the number of samples taken. It sits between the block-RAM read port and the FSM, which reads `max` when it stops the scan.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of `douta` and `max`.
- `CNT_WIDTH`, default 16: width of `maxIndex` and `sampleCount`.

Ports:
- `clk`  in  1: single system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `startFromFSM`  in  1: scan enable from the FSM; each high cycle samples one word.
- `douta`  in  DATA_WIDTH: data word from the RAM read port, unsigned.
- `max`  out  DATA_WIDTH: registered running maximum of the current run.
- `maxIndex`  out  CNT_WIDTH: 0-based sample position of the current `max`.
- `sampleCount`  out  CNT_WIDTH: number of samples taken in the current run.
- `newMax`  out  1: one-cycle registered pulse, high in the cycle after `max` changed value or was first loaded.

## Operation
- One clock, one reset: synchronous, active-high `reset`; `clk` is the only clock.
- Reset values: `max`=0, `maxIndex`=0, `sampleCount`=0, `newMax`=0, run-active flag=0.
- A run starts on the first cycle `startFromFSM` is high while the run-active flag is 0. In that cycle:
  - `max` <= `douta` unconditionally.
  - `maxIndex` <= 0, `sampleCount` <= 1, `newMax` <= 1, run-active flag <= 1.
- On each later cycle with `startFromFSM` high:
  - If `douta` > `max` (unsigned, strictly greater): `max` <= `douta`, `maxIndex` <= `sampleCount`, `newMax` <= 1.
  - Otherwise `max` and `maxIndex` hold and `newMax` <= 0.
  - `sampleCount` increments and saturates at 2^CNT_WIDTH-1.
  - Once saturated, `maxIndex` saturates with it and the compare still updates `max`.
- Ties keep the earlier sample, so `maxIndex` is the first occurrence of the maximum.
- Cycle with `startFromFSM` low: all values hold, `newMax` <= 0, run-active flag <= 0. The next high cycle starts a new run.
- `reset` has priority over everything. Reset in the middle of a run clears all state. If `startFromFSM` is high in the cycle after reset, that cycle begins a new run.
- No X handling: `douta` is trusted valid whenever `startFromFSM` is high.

## Timing
- Latency: `douta` sampled at edge N is reflected in `max`, `maxIndex`, `sampleCount` and `newMax` right after edge N.
- All outputs are registers. There is no combinational path from inputs to outputs.
- Throughput: one sample per clock, no stalls and no backpressure.
- The FSM lowers `startFromFSM` after the last word. The outputs then stay stable until the next run or `reset`.

## Structure
- Single flat module `comparador_find_max`; no sub-module is needed.
- Optional: factor the compare and select into a combinational `max_select` sub-module (inputs a, b; outputs greater and value).
- The shared package `find_max_pkg` holds:
  - `DATA_WIDTH` and `CNT_WIDTH` defaults.
  - A typedef for the data word.
  - The counter saturation constant.

## Test plan
- Reset: hold `reset`=1 with `startFromFSM`=0 and `douta`=0 for 5 cycles -> `max`=0, `maxIndex`=0, `sampleCount`=0, `newMax`=0.
- Basic scan: `startFromFSM`=1 with `douta` sequence 0, 1, 5, 4, 6, 5, 0x0878, one word per cycle -> `max` goes 0, 1, 5, 5, 6, 6, 0x0878. Final `maxIndex`=6, `sampleCount`=7. `newMax` pulses after the words 0, 1, 5, 6 and 0x0878 only.
- Ties and hold: sequence 7, 7, 3, then `startFromFSM`=0 for 4 cycles -> `max`=7, `maxIndex`=0, `sampleCount`=3. All outputs stay frozen while start is low.
- New run: after a run ending with `max`=0x0878, restart with the sequence 2, 1 -> the first cycle loads `max`=2, `maxIndex`=0, `sampleCount`=1. Final `max`=2.
- Reset mid-run: after words 9 and 0xFFFF, assert `reset` for 1 cycle with start still high, then send 3 -> all outputs clear, then `max`=3, `sampleCount`=1.
- Boundary: with CNT_WIDTH=4, feed 20 increasing words -> `sampleCount` saturates at 15. `max` equals the final word.

Source files
------------

// File: rtl/find_max_pkg.sv
// Shared definitions for the findMax datapath.
// Contents: default widths, data word typedef, counter saturation constant.
// No ports; imported by comparador_find_max and max_select.
package find_max_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Largest value a default-width sample counter can hold before it sticks.
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

endpackage

// File: rtl/comparador_find_max_max_select.sv
// Purpose: unsigned compare-and-select between a new word and the running max.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it is a pure function of its inputs.
// Ports: a (candidate word), b (current max), greater (a > b strictly),
//        value (the larger of the two; b wins ties).
module max_select
    import find_max_pkg::*;
#(
    parameter int DATA_WIDTH = find_max_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  greater,
    output logic [DATA_WIDTH-1:0] value
);

    // Strict compare so an equal later sample never displaces the earlier one.
    always_comb begin
        greater = (a > b);
        value   = greater ? a : b;
    end

endmodule

// File: rtl/comparador_find_max.sv
// Purpose: streaming unsigned maximum finder between the RAM read port and the FSM.
// Latency: douta sampled at edge N is visible on all outputs right after edge N.
// Backpressure: none; one sample per clock while startFromFSM is high.
// Ports: clk, reset (sync, active-high), startFromFSM (scan enable), douta (RAM word);
//        max (running maximum), maxIndex (first position of max), sampleCount
//        (samples in this run, saturating), newMax (pulse after max was loaded/raised).
module comparador_find_max
    import find_max_pkg::*;
#(
    parameter int DATA_WIDTH = find_max_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = find_max_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startFromFSM,
    input  logic [DATA_WIDTH-1:0] douta,
    output logic [DATA_WIDTH-1:0] max,
    output logic [CNT_WIDTH-1:0]  maxIndex,
    output logic [CNT_WIDTH-1:0]  sampleCount,
    output logic                  newMax
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Set after the first sample of a run; a low start cycle closes the run so
    // the next high cycle loads unconditionally instead of comparing.
    logic                  active;
    logic                  greater;
    logic [DATA_WIDTH-1:0] sel_value;

    max_select #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_max_select (
        .a       (douta),
        .b       (max),
        .greater (greater),
        .value   (sel_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            max         <= '0;
            maxIndex    <= '0;
            sampleCount <= '0;
            newMax      <= 1'b0;
            active      <= 1'b0;
        end else if (startFromFSM) begin
            if (!active) begin
                max         <= douta;
                maxIndex    <= '0;
                sampleCount <= CNT_WIDTH'(1);
                newMax      <= 1'b1;
                active      <= 1'b1;
            end else begin
                max    <= sel_value;
                newMax <= greater;
                // sampleCount equals this sample's 0-based position, and it
                // sticks at CNT_MAX, so maxIndex saturates along with it.
                if (greater) begin
                    maxIndex <= sampleCount;
                end
                if (sampleCount != CNT_MAX) begin
                    sampleCount <= sampleCount + CNT_WIDTH'(1);
                end
            end
        end else begin
            newMax <= 1'b0;
            active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comparador_find_max.sv
// Bench for comparador_find_max: two instances (CNT_WIDTH 16 and 4) share stimulus.
// A queue-based model of the current run predicts every output each cycle,
// and hand-computed literals pin key points of each directed scenario.
module tb_comparador_find_max;

    logic        clk;
    logic        reset;
    logic        startFromFSM;
    logic [15:0] douta;

    logic [15:0] max_a, max_b;
    logic [15:0] idx_a, cnt_a;
    logic [3:0]  idx_b, cnt_b;
    logic        new_a, new_b;

    comparador_find_max #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .startFromFSM(startFromFSM), .douta(douta),
        .max(max_a), .maxIndex(idx_a), .sampleCount(cnt_a), .newMax(new_a)
    );

    comparador_find_max #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .startFromFSM(startFromFSM), .douta(douta),
        .max(max_b), .maxIndex(idx_b), .sampleCount(cnt_b), .newMax(new_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the samples of the current run; outputs derived from the whole list.
    logic [15:0] run_q[$];
    bit          m_active = 1'b0;
    logic [15:0] m_max    = '0;
    int          m_idx    = 0;
    int          m_cnt    = 0;
    bit          m_new    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            run_q.delete();
            m_active = 1'b0;
            m_max    = '0;
            m_idx    = 0;
            m_cnt    = 0;
            m_new    = 1'b0;
        end else if (startFromFSM) begin
            logic [15:0] prev_max;
            logic [15:0] mx;
            int          first;
            if (!m_active) run_q.delete();
            m_active = 1'b1;
            run_q.push_back(douta);
            prev_max = m_max;
            mx = run_q[0];
            first = 0;
            foreach (run_q[i]) if (run_q[i] > mx) begin
                mx = run_q[i];
                first = i;
            end
            m_new = (run_q.size() == 1) || (mx != prev_max);
            m_max = mx;
            m_idx = first;
            m_cnt = run_q.size();
        end else begin
            m_active = 1'b0;
            m_new    = 1'b0;
        end
    end

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_max",   max_a, m_max);
            chk("a_index", idx_a, sat(m_idx, 65535));
            chk("a_count", cnt_a, sat(m_cnt, 65535));
            chk("a_newmax", new_a, m_new);
            chk("b_max",   max_b, m_max);
            chk("b_index", idx_b, sat(m_idx, 15));
            chk("b_count", cnt_b, sat(m_cnt, 15));
            chk("b_newmax", new_b, m_new);
        end
    end

    // Drive at a negedge; return at the next negedge, after the edge that used them.
    task automatic step(input logic s, input logic [15:0] d);
        startFromFSM = s;
        douta        = d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        startFromFSM = 1'b0;
        douta = '0;
        @(negedge clk);

        // Reset
        repeat (5) step(1'b0, 16'h0);
        chk_en = 1'b1;
        chk("lit_rst_max", max_a, 0);
        chk("lit_rst_cnt", cnt_a, 0);
        chk("lit_rst_idx", idx_a, 0);
        chk("lit_rst_new", new_a, 0);
        reset = 1'b0;

        // Basic scan
        step(1'b1, 16'd0);
        chk("lit_first_new", new_a, 1);
        chk("lit_first_cnt", cnt_a, 1);
        step(1'b1, 16'd1);
        step(1'b1, 16'd5);
        step(1'b1, 16'd4);
        chk("lit_hold_max", max_a, 5);
        chk("lit_hold_new", new_a, 0);
        step(1'b1, 16'd6);
        step(1'b1, 16'd5);
        step(1'b1, 16'h0878);
        chk("lit_scan_max", max_a, 16'h0878);
        chk("lit_scan_idx", idx_a, 6);
        chk("lit_scan_cnt", cnt_a, 7);
        chk("lit_scan_new", new_a, 1);
        step(1'b0, 16'd0);

        // Ties and hold
        step(1'b1, 16'd7);
        step(1'b1, 16'd7);
        step(1'b1, 16'd3);
        repeat (4) step(1'b0, 16'hABCD);
        chk("lit_tie_max", max_a, 7);
        chk("lit_tie_idx", idx_a, 0);
        chk("lit_tie_cnt", cnt_a, 3);
        chk("lit_tie_new", new_a, 0);

        // New run after a run ending at 0x0878
        step(1'b1, 16'h0878);
        step(1'b0, 16'd0);
        step(1'b1, 16'd2);
        chk("lit_new_max", max_a, 2);
        chk("lit_new_idx", idx_a, 0);
        chk("lit_new_cnt", cnt_a, 1);
        step(1'b1, 16'd1);
        chk("lit_new_final", max_a, 2);
        step(1'b0, 16'd0);

        // Reset mid-run with start still high
        step(1'b1, 16'd9);
        step(1'b1, 16'hFFFF);
        chk("lit_pre_rst_max", max_a, 16'hFFFF);
        reset = 1'b1;
        step(1'b1, 16'd5);
        chk("lit_midrst_max", max_a, 0);
        chk("lit_midrst_cnt", cnt_a, 0);
        reset = 1'b0;
        step(1'b1, 16'd3);
        chk("lit_after_rst_max", max_a, 3);
        chk("lit_after_rst_cnt", cnt_a, 1);
        step(1'b0, 16'd0);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) step(1'b1, 16'(100 + 3 * i));
        chk("lit_sat_b_cnt", cnt_b, 15);
        chk("lit_sat_b_idx", idx_b, 15);
        chk("lit_sat_b_max", max_b, 157);
        chk("lit_sat_a_cnt", cnt_a, 20);
        chk("lit_sat_a_idx", idx_a, 19);
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
